// File: rtl/gpu_mat_xfer.sv
`default_nettype none
// ============================================================================
//  Module   : gpu_mat_xfer
//  Brief    : Host-side initiator sequencing gpu_core vector LOAD/STORE and
//             column MUL commands.
//             Optional GPU_XFER_IDENT_EN turns op 11 into an identity fill.
//  Revision : 1.0  initial release
// ============================================================================
module gpu_mat_xfer #(
    parameter int MAT_COUNT = 4,
    localparam int MI = (MAT_COUNT > 1) ? $clog2(MAT_COUNT) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_op,
    input  logic [MI-1:0] req_mat,
    input  logic [MI-1:0] req_dst,
    input  logic [MI-1:0] req_mul,
    input  logic [1:0]    req_vtype,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [63:0]   in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [63:0]   out_data,
    output logic          done,
    output logic [MI-1:0] gpu_dat_mat_idx,
    output logic [1:0]    gpu_dat_vector_type,
    output logic [1:0]    gpu_dat_vector_idx,
    output logic [63:0]   gpu_dat_in,
    input  logic [63:0]   gpu_dat_out,
    output logic          gpu_cyc,
    output logic          gpu_dat_we,
    output logic [15:0]   gpu_command,
    output logic          gpu_com_we
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_STORE = 3'd2,
        S_MUL   = 3'd3,
        S_IDENT = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t        r_state;
    logic [1:0]    r_vidx;
    logic [MI-1:0] r_mat;
    logic [MI-1:0] r_dst;
    logic [MI-1:0] r_mul;
    logic [1:0]    r_vtype;

    logic [1:0]    w_mat2;
    logic [1:0]    w_dst2;
    logic [1:0]    w_mul2;

    assign w_mat2 = 2'(r_mat);
    assign w_dst2 = 2'(r_dst);
    assign w_mul2 = 2'(r_mul);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_vidx  <= 2'd0;
            r_mat   <= '0;
            r_dst   <= '0;
            r_mul   <= '0;
            r_vtype <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_mat   <= req_mat;
                        r_dst   <= req_dst;
                        r_mul   <= req_mul;
                        r_vtype <= req_vtype;
                        r_vidx  <= 2'd0;
                        case (req_op)
                            2'b00:   r_state <= S_LOAD;
                            2'b01:   r_state <= S_STORE;
                            2'b10:   r_state <= S_MUL;
`ifdef GPU_XFER_IDENT_EN
                            default: r_state <= S_IDENT;
`else
                            default: r_state <= S_DONE;
`endif
                        endcase
                    end
                end
                // vidx wraps back to 0 on the final beat, ready for the next op
                S_LOAD: begin
                    if (in_valid) begin
                        r_vidx <= r_vidx + 2'd1;
                        if (r_vidx == 2'd3) r_state <= S_DONE;
                    end
                end
                S_STORE: begin
                    if (out_ready) begin
                        r_vidx <= r_vidx + 2'd1;
                        if (r_vidx == 2'd3) r_state <= S_DONE;
                    end
                end
                S_MUL, S_IDENT: begin
                    r_vidx <= r_vidx + 2'd1;
                    if (r_vidx == 2'd3) r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Strobes decode from the registered state so reset clears them at once
    always_comb begin
        req_ready           = (r_state == S_IDLE);
        done                = (r_state == S_DONE);
        in_ready            = 1'b0;
        out_valid           = 1'b0;
        out_data            = 64'd0;
        gpu_cyc             = 1'b0;
        gpu_dat_we          = 1'b0;
        gpu_dat_mat_idx     = '0;
        gpu_dat_vector_type = 2'd0;
        gpu_dat_vector_idx  = 2'd0;
        gpu_dat_in          = 64'd0;
        gpu_command         = 16'd0;
        gpu_com_we          = 1'b0;
        case (r_state)
            S_LOAD: begin
                gpu_cyc             = 1'b1;
                in_ready            = 1'b1;
                gpu_dat_we          = in_valid;
                gpu_dat_in          = in_data;
                gpu_dat_mat_idx     = r_mat;
                gpu_dat_vector_type = r_vtype;
                gpu_dat_vector_idx  = r_vidx;
            end
            S_STORE: begin
                gpu_cyc             = 1'b1;
                out_valid           = 1'b1;
                out_data            = gpu_dat_out;
                gpu_dat_mat_idx     = r_mat;
                gpu_dat_vector_type = r_vtype;
                gpu_dat_vector_idx  = r_vidx;
            end
            S_MUL: begin
                gpu_com_we  = 1'b1;
                gpu_command = {8'h00, w_mul2, w_dst2, w_mat2, r_vidx};
            end
`ifdef GPU_XFER_IDENT_EN
            S_IDENT: begin
                gpu_cyc             = 1'b1;
                gpu_dat_we          = 1'b1;
                gpu_dat_mat_idx     = r_mat;
                gpu_dat_vector_idx  = r_vidx;
                gpu_dat_in          = 64'h1000 << {r_vidx, 4'b0000};
            end
`endif
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_gpu_mat_xfer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gpu_mat_xfer
//  Brief    : Self-checking bench for gpu_mat_xfer with a behavioural core.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gpu_mat_xfer;

    localparam int MAT_COUNT = 4;
    localparam int MI = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready;
    logic [1:0]    req_op;
    logic [MI-1:0] req_mat, req_dst, req_mul;
    logic [1:0]    req_vtype;
    logic          in_valid, in_ready;
    logic [63:0]   in_data;
    logic          out_valid, out_ready;
    logic [63:0]   out_data;
    logic          done;
    logic [MI-1:0] gpu_dat_mat_idx;
    logic [1:0]    gpu_dat_vector_type, gpu_dat_vector_idx;
    logic [63:0]   gpu_dat_in, gpu_dat_out;
    logic          gpu_cyc, gpu_dat_we, gpu_com_we;
    logic [15:0]   gpu_command;

    always #5 clk = ~clk;

    gpu_mat_xfer #(.MAT_COUNT(MAT_COUNT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_mat(req_mat), .req_dst(req_dst), .req_mul(req_mul), .req_vtype(req_vtype),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .done(done),
        .gpu_dat_mat_idx(gpu_dat_mat_idx), .gpu_dat_vector_type(gpu_dat_vector_type),
        .gpu_dat_vector_idx(gpu_dat_vector_idx), .gpu_dat_in(gpu_dat_in),
        .gpu_dat_out(gpu_dat_out), .gpu_cyc(gpu_cyc), .gpu_dat_we(gpu_dat_we),
        .gpu_command(gpu_command), .gpu_com_we(gpu_com_we)
    );

    // Behavioural gpu_core storage: mem[matrix][row][col], one 4.12 element each
    logic [15:0] mem [MAT_COUNT][4][4];
    logic        mem_clr = 1'b1;
    int          wr_count = 0;
    int          done_count = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    function automatic int row_of(input int vt, input int k, input int lane);
        return (vt == 1) ? k : lane;
    endfunction

    function automatic int col_of(input int vt, input int k, input int lane);
        case (vt)
            0:       return k;
            1:       return lane;
            2:       return (lane + k) % 4;
            default: return (3 - lane + k) % 4;
        endcase
    endfunction

    function automatic logic [63:0] read_vec(input int m, input int vt, input int k);
        logic [63:0] v;
        v = 64'd0;
        for (int l = 0; l < 4; l++) v[16*l +: 16] = mem[m][row_of(vt, k, l)][col_of(vt, k, l)];
        return v;
    endfunction

    always_comb begin
        gpu_dat_out = 64'd0;
        for (int l = 0; l < 4; l++)
            gpu_dat_out[16*l +: 16] = mem[gpu_dat_mat_idx]
                [row_of(int'(gpu_dat_vector_type), int'(gpu_dat_vector_idx), l)]
                [col_of(int'(gpu_dat_vector_type), int'(gpu_dat_vector_idx), l)];
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int m = 0; m < MAT_COUNT; m++)
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++) mem[m][r][c] <= 16'd0;
        end else if (gpu_cyc && gpu_dat_we) begin
            for (int l = 0; l < 4; l++)
                mem[gpu_dat_mat_idx]
                   [row_of(int'(gpu_dat_vector_type), int'(gpu_dat_vector_idx), l)]
                   [col_of(int'(gpu_dat_vector_type), int'(gpu_dat_vector_idx), l)]
                    <= gpu_dat_in[16*l +: 16];
        end
        if (gpu_cyc && gpu_dat_we) wr_count <= wr_count + 1;
        if (done) done_count <= done_count + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send_req(input logic [1:0] op, input int m, input int d, input int mu, input int vt);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_mat   = MI'(m);
        req_dst   = MI'(d);
        req_mul   = MI'(mu);
        req_vtype = 2'(vt);
        #1 chk("req_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic done_seq(input string tag);
        @(negedge clk);
        #1;
        chk({tag, "_done"}, 64'({done, gpu_cyc, gpu_com_we, req_ready, in_ready, out_valid}), 64'b100000);
        @(negedge clk);
        #1;
        chk({tag, "_idle"}, 64'({done, req_ready}), 64'b01);
    endtask

    // gappy: 1 valid then 2 idle; otherwise random valid with ~75% density
    task automatic do_load(input int m, input int vt, input logic [63:0] w [4], input bit gappy);
        int k, cyc;
        send_req(2'b00, m, 0, 0, vt);
        k = 0;
        cyc = 0;
        while (k < 4 && cyc < 40) begin
            @(negedge clk);
            in_valid = gappy ? (cyc % 3 == 0) : ($urandom_range(0, 3) != 0);
            in_data  = in_valid ? w[k] : {$urandom, $urandom};
            #1;
            chk("load_strb", 64'({gpu_cyc, in_ready, gpu_dat_we, gpu_com_we}), 64'({3'b110 | {2'b00, in_valid}, 1'b0}));
            if (in_valid) begin
                chk("load_addr", 64'({gpu_dat_mat_idx, gpu_dat_vector_type, gpu_dat_vector_idx}),
                    64'({2'(m), 2'(vt), 2'(k)}));
                chk("load_data", gpu_dat_in, w[k]);
                k++;
            end
            cyc++;
        end
        chk("load_beats", 64'(k), 64'd4);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("load_done", 64'({done, gpu_cyc, gpu_dat_we, in_ready}), 64'b1000);
        @(negedge clk);
        #1 chk("load_idle", 64'({done, req_ready}), 64'b01);
    endtask

    task automatic do_store(input int m, input int vt, input logic [63:0] exp [4], input int stall_beat);
        int k, cyc, st;
        send_req(2'b01, m, 0, 0, vt);
        k = 0;
        cyc = 0;
        st = 0;
        while (k < 4 && cyc < 40) begin
            @(negedge clk);
            out_ready = !(k == stall_beat && st < 3);
            #1;
            chk("store_strb", 64'({gpu_cyc, out_valid, gpu_dat_we, in_ready}), 64'b1100);
            chk("store_vidx", 64'(gpu_dat_vector_idx), 64'(k));
            chk("store_data", out_data, exp[k]);
            if (out_ready) k++;
            else st++;
            cyc++;
        end
        chk("store_beats", 64'(k), 64'd4);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk("store_done", 64'({done, gpu_cyc, out_valid}), 64'b100);
        @(negedge clk);
        #1 chk("store_idle", 64'({done, req_ready}), 64'b01);
    endtask

    task automatic do_mul(input int m, input int d, input int mu);
        send_req(2'b10, m, d, mu, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            chk("mul_strb", 64'({gpu_com_we, gpu_cyc, gpu_dat_we, done}), 64'b1000);
            chk("mul_cmd", 64'(gpu_command), 64'(mu * 64 + d * 16 + m * 4 + c));
        end
        done_seq("mul");
        chk("mul_cmd_idle", 64'(gpu_command), 64'd0);
    endtask

    initial begin
        logic [63:0] w [4];
        logic [63:0] e [4];
        int wc, dc, m, vt;

        rst_n = 1'b0;
        req_valid = 1'b0; req_op = 2'b00; req_mat = '0; req_dst = '0; req_mul = '0; req_vtype = 2'b00;
        in_valid = 1'b0; in_data = 64'd0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_strb", 64'({done, out_valid, in_ready, gpu_cyc, gpu_dat_we, gpu_com_we}), 64'd0);
        chk("rst_outs", 64'({gpu_command, gpu_dat_mat_idx, gpu_dat_vector_type, gpu_dat_vector_idx}), 64'd0);
        chk("rst_din", gpu_dat_in, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_clr = 1'b0;
        #1 chk("rst_ready", 64'(req_ready), 64'd1);

        // Directed LOAD of mat 1 columns, then read them back
        w = '{64'h0000_0000_0000_1000, 64'h0000_0000_1000_0000,
              64'h0000_1000_0000_0000, 64'h1000_0000_0000_0000};
        do_load(1, 0, w, 1'b0);
        do_store(1, 0, w, -1);
        do_store(1, 0, w, 2);
        do_mul(0, 2, 1);

        for (int i = 0; i < 4; i++) w[i] = {$urandom, $urandom};
        m = $urandom_range(0, 3);
        vt = $urandom_range(0, 3);
        do_load(m, vt, w, 1'b1);
        do_store(m, vt, w, $urandom_range(0, 3));

        for (int it = 0; it < 8; it++) begin
            m = $urandom_range(0, 3);
            vt = $urandom_range(0, 3);
            case ($urandom_range(0, 2))
                0: begin
                    for (int i = 0; i < 4; i++) w[i] = {$urandom, $urandom};
                    do_load(m, vt, w, 1'(it & 1));
                end
                1: begin
                    for (int i = 0; i < 4; i++) e[i] = read_vec(m, vt, i);
                    do_store(m, vt, e, $urandom_range(0, 4));
                end
                default: do_mul(m, $urandom_range(0, 3), $urandom_range(0, 3));
            endcase
        end

        // Reset asserted while beat 2 of a LOAD is presented
        send_req(2'b00, 3, 0, 0, 0);
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data = {$urandom, $urandom};
        end
        @(negedge clk);
        in_data = {$urandom, $urandom};
        #1;
        wc = wr_count;
        dc = done_count;
        chk("rst_pre_we", 64'(gpu_dat_we), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_strb", 64'({done, out_valid, in_ready, gpu_cyc, gpu_dat_we, gpu_com_we}), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("rst_rel_ready", 64'(req_ready), 64'd1);
        chk("rst_writes", 64'(wr_count), 64'(wc));
        chk("rst_nodone", 64'(done_count), 64'(dc));
        chk("rst_kept_col1", 64'(mem[3][0][1] !== 16'd0 || mem[3][1][1] !== 16'd0 ||
                                 mem[3][2][1] !== 16'd0 || mem[3][3][1] !== 16'd0 ||
                                 mem[3][0][0] !== 16'd0 || mem[3][3][0] !== 16'd0), 64'd1);
        do_mul(3, 1, 2);

        // op 11
        wc = wr_count;
        m = $urandom_range(0, 3);
        send_req(2'b11, m, 0, 0, 2);
`ifdef GPU_XFER_IDENT_EN
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            chk("ident_strb", 64'({gpu_cyc, gpu_dat_we, gpu_com_we, done}), 64'b1100);
            chk("ident_addr", 64'({gpu_dat_mat_idx, gpu_dat_vector_type, gpu_dat_vector_idx}),
                64'({2'(m), 2'b00, 2'(c)}));
            chk("ident_data", gpu_dat_in, 64'h1000 << (16 * c));
        end
        done_seq("ident");
        chk("ident_writes", 64'(wr_count - wc), 64'd4);
        for (int i = 0; i < 4; i++) e[i] = 64'h1000 << (16 * i);
        do_store(m, 0, e, -1);
`else
        done_seq("nop");
        chk("nop_writes", 64'(wr_count), 64'(wc));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
